spi_slave: RTL

SPI responder for the far end of the existing 8-bit SPI initiator link. Mode 0 (CPOL=0, CPHA=0), MSB first. Oversamples `sclk`, `cs` and `mosi` in the local `clk` domain. Returns a byte from a one-entry transmit holding register on `miso` while capturing the incoming byte from `mosi`. Sits between the SPI pins and a local byte-stream client.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 34 +++
 rtl/spi_slave.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;

  // Word width used by the existing 8-bit initiator link.
  localparam int SPI_WIDTH = 8;

  // Frame-level states of the responder.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_slave_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage pin synchronizer with registered rise/fall strobes.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer and compare against the previous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI responder oversampled in the local clk domain.
// One-entry transmit holding register feeds miso; received words go to rxd.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] txd,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rxd,
  output logic             validout,
  output logic             busy,
  output logic             underrun
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  spi_slave_state_t state;
  logic [CNT_W-1:0] cnt;
  logic             wait_fall;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  logic hold_wr, abort, do_load, do_rx, do_tx;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Chip select idles high, so its synchronizer resets high (busy low).
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  assign tx_ready = ~hold_full;
  assign hold_wr  = tx_valid & tx_ready;
  assign busy     = ~cs_level;
  assign miso     = tx_shift[WIDTH-1];

  // A chip-select rise outside IDLE abandons the frame and wins over any sclk strobe.
  assign abort   = cs_rise & (state != IDLE);
  // Reload happens either in LOAD or on the sclk fall that follows a completed word.
  assign do_load = ~abort & ((state == LOAD) |
                             ((state == SHIFT) & wait_fall & sclk_fall));
  assign do_rx   = ~abort & (state == SHIFT) & ~wait_fall & sclk_rise;
  assign do_tx   = ~abort & (state == SHIFT) & ~wait_fall & sclk_fall;

  // Holding-register payload and receive shifter carry no reset; control qualifies them
  always_ff @(posedge clk) begin
    if (hold_wr) hold_data <= txd;
    if (do_rx)   rx_shift  <= {rx_shift[WIDTH-2:0], mosi_s};
  end

  // Frame FSM, bit counter, holding-register flag, transmit shifter and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wait_fall <= 1'b0;
      hold_full <= 1'b0;
      tx_shift  <= '0;
      rxd       <= '0;
      validout  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      validout <= 1'b0;
      underrun <= 1'b0;
      if (hold_wr) hold_full <= 1'b1;
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        wait_fall <= 1'b0;
        tx_shift  <= '0;
      end else begin
        // A write landing in the same cycle as a load is not seen by that load.
        if (do_load) begin
          if (hold_full) begin
            tx_shift  <= hold_data;
            hold_full <= 1'b0;
          end else begin
            tx_shift <= '0;
            underrun <= 1'b1;
          end
        end
        if (do_tx) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        case (state)
          IDLE: begin
            cnt       <= '0;
            wait_fall <= 1'b0;
            tx_shift  <= '0;
            if (cs_fall) state <= LOAD;
          end
          LOAD: state <= SHIFT;
          SHIFT: begin
            if (wait_fall && sclk_fall) wait_fall <= 1'b0;
            if (do_rx) begin
              if (cnt == LAST) state <= DONE;
              else             cnt   <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            rxd       <= rx_shift;
            validout  <= 1'b1;
            cnt       <= '0;
            wait_fall <= 1'b1;
            state     <= SHIFT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
